// File: rtl/mux_sel_rr_sequencer.sv
// Round-robin sequencer for a 4:1 selector mux: grants one requesting channel at a time,
// holds it for DWELL_CYCLES unstalled cycles, and drives registered select/enable/grant outputs.
module mux_sel_rr_sequencer #(
    parameter int unsigned DWELL_CYCLES = 4,
    parameter int unsigned CNT_W        = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_req,
    input  logic       i_stall,
    output logic [1:0] o_sel_code,
    output logic       o_en,
    output logic [3:0] o_grant,
    output logic       o_busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    state_e           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic             en_q, en_d;
    logic [3:0]       grant_q, grant_d;
    logic             end_grant_s;
    logic [2:0]       pick_s;

    // Returns {found, index} of the first set request bit at or after start, wrapping modulo 4.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (req[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Next-state logic: decide whether the current grant ends, then arbitrate for the next owner.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        en_d        = en_q;
        grant_d     = grant_q;
        end_grant_s = 1'b0;
        pick_s      = rr_pick(i_req, ptr_q);

        case (state_q)
            IDLE: begin
                end_grant_s = 1'b1;
            end
            GRANT: begin
                // Withdrawal outranks stall so a dropped channel never holds the mux.
                if (!i_req[sel_q]) begin
                    end_grant_s = 1'b1;
                end else if (i_stall) begin
                    end_grant_s = 1'b0;
                end else if (cnt_q != {CNT_W{1'b0}}) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    end_grant_s = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (end_grant_s) begin
            if (pick_s[2]) begin
                state_d = GRANT;
                ptr_d   = pick_s[1:0] + 2'd1;
                cnt_d   = DWELL_LAST;
                sel_d   = pick_s[1:0];
                en_d    = 1'b1;
                grant_d = 4'b0001 << pick_s[1:0];
            end else begin
                state_d = IDLE;
                en_d    = 1'b0;
                grant_d = 4'b0000;
            end
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers with asynchronous active-high reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            cnt_q   <= {CNT_W{1'b0}};
            sel_q   <= 2'd0;
            en_q    <= 1'b0;
            grant_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            grant_q <= grant_d;
        end
    end

    assign o_sel_code = sel_q;
    assign o_en       = en_q;
    assign o_grant    = grant_q;
    assign o_busy     = (state_q == GRANT);

endmodule

// File: doc/mux_sel_rr_sequencer.md
Name: mux_sel_rr_sequencer

Overview:
- Upstream control stage for the 4:1 8-bit selector mux.
- Arbitrates four channel requests round-robin and drives the mux select code and enable.
- Each granted channel holds the mux for a programmable dwell time, so exactly one 8-bit source is forwarded at a time.
- Registered outputs connect directly to the mux's i_sel_code and i_en.

Parameters:
DWELL_CYCLES, 4, cycles a grant is held (legal range 1..255)
CNT_W, 8, dwell counter width; must hold DWELL_CYCLES-1

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous reset, active-high
i_req  in  4  per-channel request, bit n = channel n
i_stall  in  1  downstream not ready; freezes the dwell count
o_sel_code  out  2  binary index of the granted channel (to mux i_sel_code)
o_en  out  1  mux enable; 1 while a grant is active
o_grant  out  4  one-hot grant, equal to 1<<o_sel_code when o_en=1, else 0
o_busy  out  1  1 when the state is GRANT

Behaviour:
- Reset is asynchronous, active-high, and fixed. On reset assertion all of the following take effect immediately:
  - state=IDLE
  - o_sel_code=0, o_en=0, o_grant=0, o_busy=0
  - round-robin pointer ptr=0, dwell counter cnt=0
- Reset asserted mid-grant aborts the grant at once. No grant is issued until the first rising edge after i_rst deasserts.
- Round-robin pick: search i_req starting at index ptr and ascending modulo 4. The first set bit wins.
- On every new grant of channel n:
  - ptr <= (n+1) mod 4
  - cnt <= DWELL_CYCLES-1
  - o_sel_code <= n, o_grant <= 1<<n, o_en <= 1
- State IDLE:
  - If i_req != 0 at an edge, issue a grant and go to GRANT.
  - Latency is 1 cycle: a request sampled at edge k gives o_en=1 after edge k.
  - If i_req == 0, stay in IDLE with outputs 0.
- State GRANT, evaluated each edge in this priority order:
  1. Granted channel's i_req bit is 0 (request withdrawn): the grant ends this edge, regardless of i_stall or cnt.
  2. i_stall=1: hold everything; cnt is unchanged.
  3. cnt != 0: cnt <= cnt-1.
  4. cnt == 0: the grant ends.
- End of grant:
  - If any i_req bit is set (excluding a just-withdrawn channel, which is 0 anyway), perform the round-robin pick and grant it on the same edge. This is back-to-back: no idle cycle and o_en stays 1.
  - Otherwise go to IDLE and set o_en=0, o_grant=0.
  - o_sel_code keeps its last value in IDLE.
- The granted channel stays granted for exactly DWELL_CYCLES unstalled cycles, then yields even if it is still requesting.
  - If it is the only requester, it is re-granted back-to-back (ptr wraps past it and returns).
- DWELL_CYCLES=1: every cycle is a fresh arbitration, so a single requester holds continuously.
- New requests arriving mid-grant do not preempt the current grant.
- o_grant is always zero or one-hot and always consistent with o_sel_code and o_en.

Test Plan:
- Reset: assert i_rst mid-grant with i_req=4'b0100 → o_en, o_grant, o_busy drop to 0 immediately, without a clock edge. First edge after release grants channel 2 (ptr=0, search from 0).
- Single request: i_req=4'b0010, DWELL_CYCLES=4 → one cycle later o_sel_code=1, o_en=1, o_grant=4'b0010. The grant persists continuously: re-granted every 4 cycles, no o_en gap.
- Round robin: i_req=4'b1111 held → o_sel_code sequence 0,1,2,3,0, each held 4 cycles. o_en never deasserts.
- Stall: grant ch0, assert i_stall for 3 cycles after the 2nd dwell cycle → ch0 held 7 cycles total, then ch1 is granted.
- Withdrawal: grant ch3 with i_req=4'b1001, drop bit 3 on dwell cycle 2 → next edge grants ch0 (ptr wrapped to 0). Then drop all requests → o_en=0 and state IDLE after the next edge.
- Simultaneous events: cnt==0 with i_stall=1 → no handover until i_stall=0. With i_stall=1 and the granted request withdrawn → handover happens that edge.
